lsu: RTL and testbench

- Load/store unit: the initiator side of the data-memory interface, placed between `main_ctrl`/`alu` and a handshaked data memory or bus.
- Converts the core's single-cycle `mem_rd`/`mem_wr`/`mask`/`addr`/`wr_data` access into a valid/ready request plus a response transaction.
- Stalls the core until the transaction completes.
- Performs byte-lane steering, byte enables, load sign/zero extension, misalignment detection and response timeout.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_align.sv | 43 ++++
 rtl/lsu.sv | 127 ++++++++++++
 tb/tb_lsu.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state type, access-size encodings and alignment helpers for the lsu
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_RESP,
      ST_DONE
   } lsu_state_t;

   localparam logic [2:0] MASK_B  = 3'b000;
   localparam logic [2:0] MASK_H  = 3'b001;
   localparam logic [2:0] MASK_W  = 3'b010;
   localparam logic [2:0] MASK_BU = 3'b100;
   localparam logic [2:0] MASK_HU = 3'b101;

   function automatic logic is_byte(input logic [2:0] mask);
      return (mask == MASK_B) || (mask == MASK_BU);
   endfunction

   function automatic logic is_half(input logic [2:0] mask);
      return (mask == MASK_H) || (mask == MASK_HU);
   endfunction

   // Unsupported encodings fall through to word size.
   function automatic logic is_misaligned(input logic [2:0] mask, input logic [1:0] off);
      if (is_byte(mask)) begin
         return 1'b0;
      end
      if (is_half(mask)) begin
         return off[0];
      end
      return off != 2'b00;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering for stores and lane extraction/extension for loads
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  st_mask,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata,
   input  logic [2:0]  ld_mask,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);

   logic [31:0] lane;

   always_comb begin
      st_be    = 4'b1111;
      st_wdata = st_data;
      if (is_byte(st_mask)) begin
         st_be    = 4'b0001 << st_off;
         st_wdata = {4{st_data[7:0]}};
      end else if (is_half(st_mask)) begin
         st_be    = 4'b0011 << st_off;
         st_wdata = {2{st_data[15:0]}};
      end
   end

   assign lane = ld_rdata >> {ld_off, 3'b000};

   always_comb begin
      case (ld_mask)
         MASK_B:  ld_data = {{24{lane[7]}}, lane[7:0]};
         MASK_BU: ld_data = {24'b0, lane[7:0]};
         MASK_H:  ld_data = {{16{lane[15]}}, lane[15:0]};
         MASK_HU: ld_data = {16'b0, lane[15:0]};
         MASK_W:  ld_data = lane;
         default: ld_data = lane;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: core access to valid/ready bus request plus response, with stall and timeout
module lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_rd_i,
   input  logic        mem_wr_i,
   input  logic [2:0]  mask_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wr_data_i,
   output logic        stall_o,
   output logic [31:0] rd_data_o,
   output logic        misalign_o,
   output logic        err_o,
   output logic        req_valid_o,
   input  logic        req_ready_i,
   output logic        req_we_o,
   output logic [31:0] req_addr_o,
   output logic [31:0] req_wdata_o,
   output logic [3:0]  req_be_o,
   input  logic        rsp_valid_i,
   input  logic [31:0] rsp_rdata_i,
   input  logic        rsp_err_i
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   lsu_state_t  state;
   logic [7:0]  cnt;
   logic        we_q;
   logic [2:0]  mask_q;
   logic [1:0]  off_q;
   logic        access;
   logic        misaligned;
   logic        start;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [31:0] ld_data;

   assign access     = mem_rd_i | mem_wr_i;
   assign misaligned = is_misaligned(mask_i, addr_i[1:0]);
   assign start      = (state == ST_IDLE) && access && !misaligned;

   // Gated by rst so every output reads 0 while reset is held, even with a live core request.
   assign stall_o    = rst && (start || (state == ST_REQ) || (state == ST_RESP));
   assign misalign_o = rst && (state == ST_IDLE) && access && misaligned;

   lsu_align u_align (
      .st_mask  (mask_i),
      .st_off   (addr_i[1:0]),
      .st_data  (wr_data_i),
      .st_be    (st_be),
      .st_wdata (st_wdata),
      .ld_mask  (mask_q),
      .ld_off   (off_q),
      .ld_rdata (rsp_rdata_i),
      .ld_data  (ld_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         cnt         <= 8'd0;
         we_q        <= 1'b0;
         mask_q      <= 3'b000;
         off_q       <= 2'b00;
         rd_data_o   <= 32'd0;
         err_o       <= 1'b0;
         req_valid_o <= 1'b0;
         req_we_o    <= 1'b0;
         req_addr_o  <= 32'd0;
         req_wdata_o <= 32'd0;
         req_be_o    <= 4'b0000;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state       <= ST_REQ;
                  we_q        <= mem_wr_i;
                  mask_q      <= mask_i;
                  off_q       <= addr_i[1:0];
                  req_valid_o <= 1'b1;
                  req_we_o    <= mem_wr_i;
                  req_addr_o  <= {addr_i[31:2], 2'b00};
                  req_wdata_o <= st_wdata;
                  req_be_o    <= st_be;
               end
            end
            ST_REQ: begin
               if (req_ready_i) begin
                  state       <= ST_RESP;
                  cnt         <= 8'd0;
                  req_valid_o <= 1'b0;
                  req_we_o    <= 1'b0;
                  req_addr_o  <= 32'd0;
                  req_wdata_o <= 32'd0;
                  req_be_o    <= 4'b0000;
               end
            end
            ST_RESP: begin
               if (rsp_valid_i) begin
                  state     <= ST_DONE;
                  err_o     <= rsp_err_i;
                  rd_data_o <= (rsp_err_i || we_q) ? 32'd0 : ld_data;
               end else if (cnt == TMO_LAST) begin
                  state     <= ST_DONE;
                  err_o     <= 1'b1;
                  rd_data_o <= 32'd0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_DONE: begin
               // The request still visible here is the one just completed; never re-issue it.
               state     <= ST_IDLE;
               err_o     <= 1'b0;
               rd_data_o <= 32'd0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - scoreboard bench for lsu with randomized accesses against a reference model
module tb_lsu;

   localparam int TMO = 4;

   typedef struct {
      bit          mis;
      logic [31:0] data;
      bit          err;
      int          stalls;
   } exp_t;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } rexp_t;

   typedef struct {
      int          rdy_dly;
      int          rsp_dly;
      bit          no_rsp;
      bit          err;
      logic [31:0] rdata;
      int          late;
   } plan_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_rd_i, mem_wr_i;
   logic [2:0]  mask_i;
   logic [31:0] addr_i, wr_data_i;
   logic        stall_o, misalign_o, err_o;
   logic [31:0] rd_data_o;
   logic        req_valid_o, req_ready_i, req_we_o;
   logic [31:0] req_addr_o, req_wdata_o;
   logic [3:0]  req_be_o;
   logic        rsp_valid_i, rsp_err_i;
   logic [31:0] rsp_rdata_i;

   int    n_cmp = 0;
   int    n_bad = 0;
   bit    mon_en = 1'b0;
   exp_t  exp_q[$];
   rexp_t rq[$];
   plan_t plan_q[$];

   always #5 clk = ~clk;

   lsu #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .mask_i(mask_i),
      .addr_i(addr_i), .wr_data_i(wr_data_i),
      .stall_o(stall_o), .rd_data_o(rd_data_o), .misalign_o(misalign_o), .err_o(err_o),
      .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_we_o(req_we_o),
      .req_addr_o(req_addr_o), .req_wdata_o(req_wdata_o), .req_be_o(req_be_o),
      .rsp_valid_i(rsp_valid_i), .rsp_rdata_i(rsp_rdata_i), .rsp_err_i(rsp_err_i)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", name, act, expv);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: access size in bytes, from the funct3 size field.
   function automatic int size_of(input logic [2:0] m);
      case (m[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [3:0] ref_be(input logic [2:0] m, input int off);
      int sz = size_of(m);
      if (sz == 4) return 4'hF;
      return 4'(((1 << sz) - 1) << off);
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] m, input logic [31:0] d);
      int sz = size_of(m);
      if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
      if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] m, input int off, input logic [31:0] rd);
      int          sz = size_of(m);
      logic [31:0] s;
      longint      v;
      s = rd >> (8 * off);
      v = longint'(s);
      if (sz < 4) begin
         v = v % (longint'(1) << (8 * sz));
         if (m[2] == 1'b0 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
      end
      return v[31:0];
   endfunction

   function automatic plan_t mk_plan(input int rdy, input int rsp, input bit no_rsp, input bit err,
                                     input logic [31:0] rdata, input int late);
      plan_t p;
      p.rdy_dly = rdy;
      p.rsp_dly = rsp;
      p.no_rsp  = no_rsp;
      p.err     = err;
      p.rdata   = rdata;
      p.late    = late;
      return p;
   endfunction

   task automatic check_all_zero(input string tag);
      chk({tag, "_stall"}, 32'(stall_o), 32'd0);
      chk({tag, "_misalign"}, 32'(misalign_o), 32'd0);
      chk({tag, "_err"}, 32'(err_o), 32'd0);
      chk({tag, "_rd_data"}, rd_data_o, 32'd0);
      chk({tag, "_req_valid"}, 32'(req_valid_o), 32'd0);
      chk({tag, "_req_fields"}, req_addr_o | req_wdata_o | {27'd0, req_we_o, req_be_o}, 32'd0);
   endtask

   task automatic issue(input bit rd, input bit wr, input logic [2:0] m, input logic [31:0] a,
                        input logic [31:0] wd, input plan_t p);
      exp_t  e;
      rexp_t r;
      int    off = int'(a[1:0]);
      int    n = 0;
      bit    done = 1'b0;
      if (!(rd || wr)) begin
         tick();
         return;
      end
      mem_rd_i  = rd;
      mem_wr_i  = wr;
      mask_i    = m;
      addr_i    = a;
      wr_data_i = wd;
      if (off % size_of(m) != 0) begin
         e.mis = 1'b1; e.data = 32'd0; e.err = 1'b0; e.stalls = 0;
         exp_q.push_back(e);
         tick();
         mem_rd_i = 1'b0;
         mem_wr_i = 1'b0;
         return;
      end
      r.we    = wr;
      r.addr  = a & 32'hFFFF_FFFC;
      r.wdata = ref_wdata(m, wd);
      r.be    = ref_be(m, off);
      rq.push_back(r);
      e.mis    = 1'b0;
      e.err    = p.err || p.no_rsp;
      e.data   = (wr || e.err) ? 32'd0 : ref_load(m, off, p.rdata);
      e.stalls = 1 + (p.rdy_dly + 1) + (p.no_rsp ? TMO : p.rsp_dly + 1);
      exp_q.push_back(e);
      plan_q.push_back(p);
      while (!done) begin
         @(negedge clk);
         if (!stall_o) begin
            done = 1'b1;
         end else begin
            n++;
            if (n > 100) begin
               fail_now("stall_never_released");
               done = 1'b1;
            end
            @(posedge clk);
            #1;
         end
      end
      tick();
      mem_rd_i = 1'b0;
      mem_wr_i = 1'b0;
   endtask

   // Bus responder: follows the plan pushed for each aligned access.
   initial begin
      plan_t p;
      int    n;
      req_ready_i = 1'b0;
      rsp_valid_i = 1'b0;
      rsp_err_i   = 1'b0;
      rsp_rdata_i = 32'd0;
      forever begin
         tick();
         if (plan_q.size() != 0) begin
            p = plan_q.pop_front();
            n = 0;
            while (!req_valid_o && n < 200) begin
               tick();
               n++;
            end
            if (!req_valid_o) fail_now("req_valid_never_rose");
            repeat (p.rdy_dly) tick();
            req_ready_i = 1'b1;
            tick();
            req_ready_i = 1'b0;
            if (!p.no_rsp || p.late > 0) begin
               repeat (p.no_rsp ? p.late : p.rsp_dly) tick();
               rsp_valid_i = 1'b1;
               rsp_rdata_i = p.rdata;
               rsp_err_i   = p.err;
               tick();
               rsp_valid_i = 1'b0;
               rsp_err_i   = 1'b0;
               rsp_rdata_i = $urandom;
            end
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a result or an accepted request.
   initial begin
      exp_t        e;
      rexp_t       r;
      bit          prev_stall;
      bit          held;
      int          stall_cnt;
      logic [31:0] s_addr, s_wdata;
      logic [3:0]  s_be;
      logic        s_we;
      prev_stall = 1'b0;
      held       = 1'b0;
      stall_cnt  = 0;
      forever begin
         @(negedge clk);
         if (mon_en && rst) begin
            if (stall_o) stall_cnt++;
            if (misalign_o) begin
               chk("misalign_stall", 32'(stall_o), 32'd0);
               chk("misalign_req", 32'(req_valid_o), 32'd0);
               if (exp_q.size() == 0) begin
                  fail_now("unexpected_misalign");
               end else begin
                  e = exp_q.pop_front();
                  chk("misalign_expected", 32'(e.mis), 32'd1);
               end
            end
            if (prev_stall && !stall_o) begin
               if (exp_q.size() == 0) begin
                  fail_now("unexpected_completion");
               end else begin
                  e = exp_q.pop_front();
                  chk("done_kind", 32'(e.mis), 32'd0);
                  chk("rd_data", rd_data_o, e.data);
                  chk("err", 32'(err_o), 32'(e.err));
                  chk("stall_cycles", stall_cnt, e.stalls);
               end
               stall_cnt = 0;
            end else begin
               chk("err_quiet", 32'(err_o), 32'd0);
               chk("rd_data_quiet", rd_data_o, 32'd0);
            end
            if (req_valid_o) begin
               if (held) begin
                  chk("req_hold_we", 32'(req_we_o), 32'(s_we));
                  chk("req_hold_addr", req_addr_o, s_addr);
                  chk("req_hold_wdata", req_wdata_o, s_wdata);
                  chk("req_hold_be", 32'(req_be_o), 32'(s_be));
               end
               s_we = req_we_o; s_addr = req_addr_o; s_wdata = req_wdata_o; s_be = req_be_o;
               chk("req_stall", 32'(stall_o), 32'd1);
               if (req_ready_i) begin
                  if (rq.size() == 0) begin
                     fail_now("unexpected_request");
                  end else begin
                     r = rq.pop_front();
                     chk("req_we", 32'(req_we_o), 32'(r.we));
                     chk("req_addr", req_addr_o, r.addr);
                     chk("req_wdata", req_wdata_o, r.wdata);
                     chk("req_be", 32'(req_be_o), 32'(r.be));
                  end
                  held = 1'b0;
               end else begin
                  held = 1'b1;
               end
            end else begin
               chk("req_idle_zero", req_addr_o | req_wdata_o | {27'd0, req_we_o, req_be_o}, 32'd0);
               held = 1'b0;
            end
         end else begin
            stall_cnt = 0;
            held      = 1'b0;
         end
         prev_stall = mon_en && rst && stall_o;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] masks [8];
      logic [2:0] m;
      bit         rd, wr, no_rsp;
      masks = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
      rst       = 1'b0;
      mem_rd_i  = 1'b1;
      mem_wr_i  = 1'b0;
      mask_i    = 3'b010;
      addr_i    = 32'h0;
      wr_data_i = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      mem_rd_i = 1'b0;
      #2;
      rst = 1'b1;
      tick();
      mon_en = 1'b1;

      issue(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, mk_plan(0, 0, 0, 0, 32'h0, 0));
      issue(1, 0, 3'b000, 32'h103, 32'h0, mk_plan(0, 0, 0, 0, 32'h80FF7F01, 0));
      issue(1, 0, 3'b100, 32'h103, 32'h0, mk_plan(0, 0, 0, 0, 32'h80FF7F01, 0));
      issue(0, 1, 3'b001, 32'h102, 32'h0000ABCD, mk_plan(0, 0, 0, 0, 32'h0, 0));
      issue(1, 0, 3'b001, 32'h102, 32'h0, mk_plan(0, 0, 0, 0, 32'h7FFF0000, 0));
      issue(1, 0, 3'b010, 32'h101, 32'h0, mk_plan(0, 0, 0, 0, 32'h0, 0));
      issue(1, 0, 3'b010, 32'h040, 32'h0, mk_plan(5, 1, 0, 0, 32'h12345678, 0));
      issue(1, 0, 3'b010, 32'h044, 32'h0, mk_plan(0, 0, 1, 0, 32'h0, 0));
      issue(1, 1, 3'b000, 32'h049, 32'h000000A5, mk_plan(1, 2, 0, 0, 32'hFFFFFFFF, 0));
      issue(0, 1, 3'b010, 32'h050, 32'h01020304, mk_plan(0, 3, 0, 1, 32'h0, 0));

      // Reset while waiting in RESP, then a stale response arrives after release.
      mon_en = 1'b0;
      plan_q.push_back(mk_plan(0, 0, 1, 0, 32'hCAFEF00D, 4));
      mem_rd_i = 1'b1;
      mem_wr_i = 1'b0;
      mask_i   = 3'b010;
      addr_i   = 32'h200;
      tick();
      tick();
      tick();
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("mid_resp_reset");
      mem_rd_i = 1'b0;
      tick();
      #2;
      rst = 1'b1;
      tick();
      tick();
      @(negedge clk);
      check_all_zero("late_rsp");
      tick();
      mon_en = 1'b1;
      issue(1, 0, 3'b010, 32'h204, 32'h0, mk_plan(0, 0, 0, 0, 32'hA5A5_5A5A, 0));

      for (int i = 0; i < 200; i++) begin
         m      = masks[$urandom_range(0, 7)];
         rd     = 1'($urandom_range(0, 1));
         wr     = 1'($urandom_range(0, 1));
         no_rsp = ($urandom_range(0, 15) == 0);
         issue(rd, wr, m, $urandom, $urandom,
               mk_plan($urandom_range(0, 3), $urandom_range(0, TMO - 1), no_rsp,
                       ($urandom_range(0, 7) == 0), $urandom, 0));
         if ($urandom_range(0, 3) == 0) tick();
      end

      repeat (10) tick();
      chk("exp_q_drained", exp_q.size(), 32'd0);
      chk("req_q_drained", rq.size(), 32'd0);
      chk("plan_q_drained", plan_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
